mux_rr_n: RTL

Parametrised N-channel round-robin arbitrating multiplexer; successor to the 2-input valid/data mux.
- Merges NUM_CH valid/data input streams onto one registered output stream.
- Fair rotating grant, pop strobes back to the source FIFOs, downstream backpressure.
- Sits between the per-lane FIFOs and the single-lane serializer/demux path.

---
 rtl/mux_rr_n_if.sv | 31 +++
 rtl/mux_rr_n.sv | 91 +++++++++
 2 files changed

// File: rtl/mux_rr_n_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_n_if
// Brief    : Stream bundle for the N-channel round-robin mux (inputs, pops,
//            registered output word with ready backpressure).
// Revision : 1.0 - initial release
// ============================================================================
interface mux_rr_n_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic [NUM_CH*DATA_W-1:0] data_in;
   logic [NUM_CH-1:0]        valid_in;
   logic [NUM_CH-1:0]        pop_in;
   logic                     ready_out;
   logic                     valid_out;
   logic [DATA_W-1:0]        data_out;
   logic [CH_W-1:0]          ch_out;

   modport slave (
      input  data_in, valid_in, ready_out,
      output pop_in, valid_out, data_out, ch_out
   );

   modport master (
      output data_in, valid_in, ready_out,
      input  pop_in, valid_out, data_out, ch_out
   );
endinterface
`default_nettype wire

// File: rtl/mux_rr_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_n
// Brief    : N-channel round-robin arbitrating mux onto one registered output.
//            Optional burst grants enabled by defining MUX_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_n #(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4
) (
   input  logic         clk,
   input  logic         reset_L,
   mux_rr_n_if.slave    bus
);
   localparam int                c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [c_CH_W-1:0] c_LAST = c_CH_W'(NUM_CH - 1);

   logic [c_CH_W-1:0] r_ptr;
   logic [c_CH_W-1:0] w_rr_grant;
   logic [c_CH_W-1:0] w_grant;
   logic [c_CH_W-1:0] w_next_ptr;
   logic [NUM_CH-1:0] w_pop;
   logic              w_free;
   logic              w_take;
   logic              w_burst_hit;
   int                w_idx;

   assign w_free = !bus.valid_out || bus.ready_out;
   assign w_take = w_free && (|bus.valid_in);

   // Descending scan so the smallest offset from r_ptr wins.
   always_comb begin
      w_rr_grant = r_ptr;
      w_idx      = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
         if (bus.valid_in[w_idx[c_CH_W-1:0]]) w_rr_grant = c_CH_W'(w_idx);
      end
   end

`ifdef MUX_BURST_EN
   logic [7:0] r_burst_cnt;

   // Counter of zero means no prior grant, so fall back to round-robin.
   assign w_burst_hit = (r_burst_cnt != 8'd0) && bus.valid_in[bus.ch_out]
                        && (r_burst_cnt < 8'(BURST_LEN));
   assign w_grant     = w_burst_hit ? bus.ch_out : w_rr_grant;

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_burst_cnt <= 8'd0;
      end else if (w_take) begin
         r_burst_cnt <= w_burst_hit ? (r_burst_cnt + 8'd1) : 8'd1;
      end
   end
`else
   logic w_unused_burst;

   assign w_unused_burst = (BURST_LEN != 0);
   assign w_burst_hit    = 1'b0;
   assign w_grant        = w_rr_grant;
`endif

   assign w_next_ptr = (w_grant == c_LAST) ? '0 : (w_grant + 1'b1);

   always_comb begin
      w_pop = '0;
      if (reset_L && w_take) w_pop[w_grant] = 1'b1;
   end
   assign bus.pop_in = w_pop;

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         bus.valid_out <= 1'b0;
         bus.data_out  <= '0;
         bus.ch_out    <= '0;
         r_ptr         <= '0;
      end else if (w_take) begin
         bus.valid_out <= 1'b1;
         bus.data_out  <= bus.data_in[w_grant*DATA_W +: DATA_W];
         bus.ch_out    <= w_grant;
         if (!w_burst_hit) r_ptr <= w_next_ptr;
      end else if (w_free) begin
         bus.valid_out <= 1'b0;
      end
   end
endmodule
`default_nettype wire
